// File: rtl/cmos_seq_pkg.sv
// Shared types and defaults for the CMOS camera clock/reset sequencer.
// Holds the sequencer state enum, the 50 MHz timing defaults, the lost-lock
// counter ceiling and a range helper used by the elaboration checks.
package cmos_seq_pkg;

  // Sequencer states, in the order they are normally walked through
  typedef enum logic [2:0] {
    ST_PLL_RST    = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_LOCK_FILT  = 3'd2,
    ST_CAM_PWDN   = 3'd3,
    ST_CAM_RST    = 3'd4,
    ST_CAM_SETTLE = 3'd5,
    ST_RUN        = 3'd6,
    ST_FAULT      = 3'd7
  } seq_state_e;

  // Default timing for a 50 MHz board clock
  localparam int DEF_CNT_W         = 20;
  localparam int DEF_PLL_RST_CYC   = 16;
  localparam int DEF_LOCK_TO_CYC   = 500000;   // 10 ms
  localparam int DEF_LOCK_FILT_CYC = 1024;
  localparam int DEF_PWDN_CYC      = 50000;    // 1 ms
  localparam int DEF_CAM_RST_CYC   = 50000;    // 1 ms
  localparam int DEF_SETTLE_CYC    = 1000000;  // 20 ms
  localparam int DEF_MAX_RETRY     = 3;

  // Lost-lock counter stops counting here
  localparam logic [7:0] LOST_SAT = 8'd255;

  // A timed phase of n cycles needs a counter that can hold n-1
  function automatic bit cyc_in_range(input longint n, input int w);
    return (n >= 1) && (n < (longint'(1) << w));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for bringing an asynchronous level
// into the clk domain. Output lags the input by two clk edges.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_ff;

  // Shift the asynchronous level through two flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ff <= 2'b00;
    else        r_ff <= {r_ff[0], i_d};
  end

  assign o_q = r_ff[1];

endmodule

// File: rtl/cmos_clk_rst_seq.sv
// Power-up and lock supervisor for the CMOS camera clock PLL.
// Holds the PLL in reset, waits for a filtered lock, then walks the camera
// PWDN/RESET pins, fires a one-cycle cfg_start to the SCCB engine and
// reports ready. Lock timeouts retry the PLL up to MAX_RETRY times before
// parking in FAULT.
// Optional feature macro: CMOS_SEQ_LOCK_MON_EN -- when defined, a lock drop
// from CAM_PWDN through RUN restarts the sequence and bumps lost_cnt; when
// undefined the lock is ignored after the filter and lost_cnt reads 0.
// All pins are registered and decoded from the next state, so they move in
// the same cycle as the state register. dbg_state mirrors the state.
module cmos_clk_rst_seq
  import cmos_seq_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int PLL_RST_CYC   = DEF_PLL_RST_CYC,
  parameter int LOCK_TO_CYC   = DEF_LOCK_TO_CYC,
  parameter int LOCK_FILT_CYC = DEF_LOCK_FILT_CYC,
  parameter int PWDN_CYC      = DEF_PWDN_CYC,
  parameter int CAM_RST_CYC   = DEF_CAM_RST_CYC,
  parameter int SETTLE_CYC    = DEF_SETTLE_CYC,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       cfg_start,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] lost_cnt,
  output logic [2:0] dbg_state
);

  // Parameter sanity, evaluated at elaboration
  if (!cyc_in_range(PLL_RST_CYC, CNT_W) || !cyc_in_range(LOCK_TO_CYC, CNT_W) ||
      !cyc_in_range(LOCK_FILT_CYC, CNT_W) || !cyc_in_range(PWDN_CYC, CNT_W) ||
      !cyc_in_range(CAM_RST_CYC, CNT_W) || !cyc_in_range(SETTLE_CYC, CNT_W)) begin : g_bad_timing
    $error("cmos_clk_rst_seq: every timing parameter must be >=1 and < 2**CNT_W");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 3) begin : g_bad_retry
    $error("cmos_clk_rst_seq: MAX_RETRY must fit the 2-bit retry counter (1..3)");
  end

  localparam logic [1:0] RETRY_LAST = 2'(MAX_RETRY - 1);

  seq_state_e       r_state;
  seq_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;
  logic             w_cnt_done;
  logic             w_enter;
  logic             w_timeout;
  logic             w_lock_s;
  logic             w_lock_loss;

  logic             r_pll_reset;
  logic             r_cam_pwdn;
  logic             r_cam_rst_n;
  logic             r_cfg_start;
  logic             r_ready;
  logic             r_fault;
  logic [1:0]       r_retry;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

`ifdef CMOS_SEQ_LOCK_MON_EN
  // Lock is watched from camera power-down onwards
  assign w_lock_loss = !w_lock_s &&
                       ((r_state == ST_CAM_PWDN) || (r_state == ST_CAM_RST) ||
                        (r_state == ST_CAM_SETTLE) || (r_state == ST_RUN));
`else
  assign w_lock_loss = 1'b0;
`endif

  // Terminal count of the current timed state (untimed states use 0)
  always_comb begin
    w_last = '0;
    case (r_state)
      ST_PLL_RST:    w_last = CNT_W'(PLL_RST_CYC - 1);
      ST_WAIT_LOCK:  w_last = CNT_W'(LOCK_TO_CYC - 1);
      ST_LOCK_FILT:  w_last = CNT_W'(LOCK_FILT_CYC - 1);
      ST_CAM_PWDN:   w_last = CNT_W'(PWDN_CYC - 1);
      ST_CAM_RST:    w_last = CNT_W'(CAM_RST_CYC - 1);
      ST_CAM_SETTLE: w_last = CNT_W'(SETTLE_CYC - 1);
      default:       w_last = '0;
    endcase
  end

  assign w_cnt_done = (r_cnt == w_last);

  // Next state: restart beats lock loss, which beats counter expiry
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    if (restart) begin
      w_next = ST_PLL_RST;
    end else if (w_lock_loss) begin
      w_next = ST_PLL_RST;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (w_cnt_done) w_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_next = ST_LOCK_FILT;
          end else if (w_cnt_done) begin
            w_timeout = 1'b1;
            w_next    = (r_retry == RETRY_LAST) ? ST_FAULT : ST_PLL_RST;
          end
        end
        ST_LOCK_FILT: begin
          // A single low sample restarts the wait with a fresh timeout
          if (!w_lock_s)       w_next = ST_WAIT_LOCK;
          else if (w_cnt_done) w_next = ST_CAM_PWDN;
        end
        ST_CAM_PWDN: begin
          if (w_cnt_done) w_next = ST_CAM_RST;
        end
        ST_CAM_RST: begin
          if (w_cnt_done) w_next = ST_CAM_SETTLE;
        end
        ST_CAM_SETTLE: begin
          if (w_cnt_done) w_next = ST_RUN;
        end
        ST_RUN:   w_next = ST_RUN;
        ST_FAULT: w_next = ST_FAULT;
        default:  w_next = ST_PLL_RST;
      endcase
    end
  end

  // A restart re-enters PLL_RST even from PLL_RST, so it also clears cnt
  assign w_enter = restart || (w_next != r_state);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_PLL_RST;
    else        r_state <= w_next;
  end

  // Phase counter: cleared on state entry, holds at terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_cnt <= '0;
    else if (w_enter)     r_cnt <= '0;
    else if (!w_cnt_done) r_cnt <= r_cnt + 1'b1;
  end

  // Pin decode from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_reset <= 1'b1;
      r_cam_pwdn  <= 1'b1;
      r_cam_rst_n <= 1'b0;
      r_cfg_start <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_pll_reset <= (w_next == ST_PLL_RST) || (w_next == ST_FAULT);
      r_cam_pwdn  <= (w_next == ST_PLL_RST) || (w_next == ST_WAIT_LOCK) ||
                     (w_next == ST_LOCK_FILT) || (w_next == ST_CAM_PWDN) ||
                     (w_next == ST_FAULT);
      r_cam_rst_n <= (w_next == ST_CAM_SETTLE) || (w_next == ST_RUN);
      r_cfg_start <= (r_state == ST_CAM_SETTLE) && (w_next == ST_RUN);
      // ready follows cfg_start by one cycle
      r_ready     <= (r_state == ST_RUN) && (w_next == ST_RUN);
      r_fault     <= (w_next == ST_FAULT);
    end
  end

  // Lock-timeout counter, cleared only by restart or rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_retry <= 2'd0;
    else if (restart)   r_retry <= 2'd0;
    else if (w_timeout) r_retry <= r_retry + 2'd1;
  end

`ifdef CMOS_SEQ_LOCK_MON_EN
  logic [7:0] r_lost;

  // Saturating count of lock losses past the filter; restart wins a tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          r_lost <= 8'd0;
    else if (!restart && w_lock_loss && r_lost != LOST_SAT) r_lost <= r_lost + 8'd1;
  end

  assign lost_cnt = r_lost;
`else
  assign lost_cnt = 8'd0;
`endif

  assign pll_reset = r_pll_reset;
  assign cam_pwdn  = r_cam_pwdn;
  assign cam_rst_n = r_cam_rst_n;
  assign cfg_start = r_cfg_start;
  assign ready     = r_ready;
  assign fault     = r_fault;
  assign retry_cnt = r_retry;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_cmos_clk_rst_seq.sv
// Bench for cmos_clk_rst_seq with every timing parameter at 4, MAX_RETRY=3.
// Each scenario fills a per-edge lock/restart table, a phase-level reference
// model turns the table into the list of expected pin changes (edge number +
// pin vector), and a monitor pops and compares one entry whenever the pins
// change. Edge 1 is the first rising clock edge after rst_n releases.
module tb_cmos_clk_rst_seq;

  localparam int CYC   = 4;
  localparam int MAXR  = 3;
  localparam int HMAX  = 200;
  localparam int W     = 32;
  localparam int NEVER = 1 << 30;
`ifdef CMOS_SEQ_LOCK_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  // Pin vector: {pll_reset, cam_pwdn, cam_rst_n, cfg_start, ready, fault, retry[1:0], lost[7:0]}
  localparam logic [15:0] RST_VEC = 16'hC000;

  localparam int PH_RST = 0, PH_WAIT = 1, PH_FILT = 2, PH_PWDN = 3;
  localparam int PH_CRST = 4, PH_SET = 5, PH_RUN = 6, PH_FAULT = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset, cam_pwdn, cam_rst_n, cfg_start, ready, fault;
  logic [1:0] retry_cnt;
  logic [7:0] lost_cnt;
  logic [2:0] dbg_state;

  int total = 0;
  int bad = 0;
  int edge_n;
  logic [W-1:0] exp_q[$];
  bit lk[0:HMAX];
  bit rs[0:HMAX];
  logic [15:0] mdl_last;
  logic [15:0] prev_vec = RST_VEC;
  logic [15:0] mon_v;
  logic [W-1:0] mon_exp;

  cmos_clk_rst_seq #(
    .CNT_W(20), .PLL_RST_CYC(CYC), .LOCK_TO_CYC(CYC), .LOCK_FILT_CYC(CYC),
    .PWDN_CYC(CYC), .CAM_RST_CYC(CYC), .SETTLE_CYC(CYC), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .restart(restart),
    .pll_reset(pll_reset), .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
    .cfg_start(cfg_start), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .lost_cnt(lost_cnt), .dbg_state(dbg_state)
  );

  // Clock and edge numbering
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  function automatic logic [15:0] cur_vec();
    return {pll_reset, cam_pwdn, cam_rst_n, cfg_start, ready, fault, retry_cnt, lost_cnt};
  endfunction

  // ---------------- reference model ----------------
  // Lock level the sequencer decides on at edge n (two-flop delay)
  function automatic int seen_at(input int n);
    if (n < 3) return 0;
    return int'(lk[n-2]);
  endfunction

  function automatic int first_seen(input int val, input int a, input int b);
    for (int n = a; n <= b && n <= HMAX; n++) if (seen_at(n) == val) return n;
    return NEVER;
  endfunction

  function automatic int first_rs(input int a, input int b);
    for (int n = a; n <= b && n <= HMAX; n++) if (rs[n]) return n;
    return NEVER;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [15:0] ph_vec(input int ph, input int retries, input int lost,
                                         input bit cfg, input bit rdy);
    bit pr, pd, rn;
    pr = (ph == PH_RST) || (ph == PH_FAULT);
    pd = (ph <= PH_PWDN) || (ph == PH_FAULT);
    rn = (ph == PH_SET) || (ph == PH_RUN);
    return {pr, pd, rn, cfg, rdy, (ph == PH_FAULT), retries[1:0], lost[7:0]};
  endfunction

  task automatic emit(input int e, input logic [15:0] v);
    if (v != mdl_last) begin
      exp_q.push_back({e[15:0], v});
      mdl_last = v;
    end
  endtask

  // Walk the sequence phase by phase up to edge h
  task automatic build_expect(input int h);
    int ph, e, retries, lost, t_exp, t_lock, t_loss, t_rs, t_end;
    ph = PH_RST; e = 0; retries = 0; lost = 0; mdl_last = RST_VEC;
    while (1) begin
      t_exp = NEVER; t_lock = NEVER; t_loss = NEVER;
      case (ph)
        PH_RST:  t_exp = e + CYC;
        PH_WAIT: begin t_exp = e + CYC; t_lock = first_seen(1, e + 1, e + CYC); end
        PH_FILT: begin t_exp = e + CYC; t_loss = first_seen(0, e + 1, e + CYC); end
        PH_PWDN, PH_CRST, PH_SET: begin
          t_exp = e + CYC;
          if (MON) t_loss = first_seen(0, e + 1, e + CYC);
        end
        PH_RUN: if (MON) t_loss = first_seen(0, e + 1, h);
        default: ;
      endcase
      t_end = min2(min2(t_exp, t_lock), t_loss);
      t_rs  = first_rs(e + 1, min2(t_end, h));
      if (ph == PH_RUN && e + 1 <= h && t_rs > e + 1 && t_loss > e + 1)
        emit(e + 1, ph_vec(PH_RUN, retries, lost, 1'b0, 1'b1));
      if (t_rs != NEVER) begin
        ph = PH_RST; retries = 0; e = t_rs;
      end else if (t_end > h) begin
        break;
      end else if (t_lock == t_end) begin
        ph = PH_FILT; e = t_end;
      end else if (t_loss == t_end) begin
        e = t_end;
        if (ph == PH_FILT) ph = PH_WAIT;
        else begin ph = PH_RST; if (lost < 255) lost++; end
      end else begin
        e = t_end;
        case (ph)
          PH_RST:  ph = PH_WAIT;
          PH_WAIT: begin retries++; ph = (retries == MAXR) ? PH_FAULT : PH_RST; end
          PH_FILT: ph = PH_PWDN;
          PH_PWDN: ph = PH_CRST;
          PH_CRST: ph = PH_SET;
          default: ph = PH_RUN;
        endcase
      end
      emit(e, ph_vec(ph, retries, lost, (ph == PH_RUN), 1'b0));
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    mon_v = cur_vec();
    if (!rst_n) begin
      prev_vec = RST_VEC;
    end else if (mon_v != prev_vec) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pin_change: got edge=%0d vec=%h, required no change", edge_n, mon_v);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({edge_n[15:0], mon_v} !== mon_exp) begin
          bad++;
          $display("FAIL pin_change: got edge=%0d vec=%h, required edge=%0d vec=%h",
                   edge_n, mon_v, mon_exp[31:16], mon_exp[15:0]);
        end
      end
      prev_vec = mon_v;
    end
  end

  // ---------------- driver ----------------
  task automatic clear_stim();
    for (int n = 0; n <= HMAX; n++) begin lk[n] = 1'b0; rs[n] = 1'b0; end
  endtask

  task automatic check_reset_pins(input string tag);
    total++;
    if (cur_vec() !== RST_VEC) begin
      bad++;
      $display("FAIL %s: got vec=%h, required %h", tag, cur_vec(), RST_VEC);
    end
  endtask

  // Release reset, play the table for edges 1..h, then reset mid-cycle
  task automatic run_scn(input string tag, input int h);
    build_expect(h);
    @(negedge clk);
    rst_n = 1'b1; pll_lock = lk[1]; restart = rs[1];
    for (int n = 2; n <= h; n++) begin
      @(negedge clk);
      pll_lock = lk[n]; restart = rs[n];
    end
    @(negedge clk);
    #1;
    pll_lock = 1'b0; restart = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_events: got %0d expected changes not seen, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    rst_n = 1'b0;
    #1;
    check_reset_pins({tag, "_async_reset"});
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int g, d, h, rise, len;
    clear_stim();
    repeat (3) @(negedge clk);
    check_reset_pins("reset_state");

    // Lock rises at edge 10
    clear_stim();
    for (int n = 10; n <= HMAX; n++) lk[n] = 1'b1;
    run_scn("lock_at_10", 40);

    // No lock: three PLL resets, FAULT, then restart with lock present
    clear_stim();
    rs[40] = 1'b1;
    for (int n = 45; n <= HMAX; n++) lk[n] = 1'b1;
    run_scn("no_lock_fault", 90);

    // One-cycle glitch while filtering
    clear_stim();
    for (int n = 9; n <= HMAX; n++) lk[n] = 1'b1;
    g = $urandom_range(12, 14);
    lk[g] = 1'b0;
    run_scn("filt_glitch", 60);

    // Lock drops while running
    clear_stim();
    for (int n = 1; n <= HMAX; n++) lk[n] = 1'b1;
    d = $urandom_range(22, 28);
    for (int n = d; n < d + 3; n++) lk[n] = 1'b0;
    run_scn("run_drop", 80);

    // Restart and lock loss on the same edge
    clear_stim();
    for (int n = 9; n <= HMAX; n++) lk[n] = 1'b1;
    d = $urandom_range(30, 34);
    for (int n = d; n < d + 3; n++) lk[n] = 1'b0;
    rs[d + 2] = 1'b1;
    run_scn("restart_vs_loss", 80);

    // rst_n asserted while in CAM_SETTLE
    clear_stim();
    for (int n = 1; n <= HMAX; n++) lk[n] = 1'b1;
    h = $urandom_range(17, 20);
    run_scn("settle_rst_n", h);

    // Random lock waveforms and restarts
    for (int k = 0; k < 8; k++) begin
      clear_stim();
      rise = $urandom_range(1, 20);
      for (int n = rise; n <= HMAX; n++) lk[n] = 1'b1;
      for (int n = rise + 5; n <= 120; n++) begin
        if ($urandom_range(0, 39) == 0) begin
          len = $urandom_range(1, 3);
          for (int j = 0; j < len; j++) lk[n + j] = 1'b0;
        end
      end
      for (int n = 1; n <= 120; n++) if ($urandom_range(0, 59) == 0) rs[n] = 1'b1;
      run_scn("random", 120);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Run-length guard
  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run, required finish before 1000000 time units");
    $fatal(1, "bench timeout");
  end

endmodule
